// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC register handshake, instruction memory read port,
// execute redirect and the in-order handoff toward decode.
// The "slave" modport is the fetch stage; "master" is its environment.
interface fetch_stage_if #(
  parameter int D_WIDTH = 32
);
  logic [D_WIDTH-1:0] PC;
  logic [D_WIDTH-1:0] PCNext;
  logic [31:0]        Instr;
  logic               RedirectE;
  logic [D_WIDTH-1:0] PCTargetE;
  logic               ValidD;
  logic               ReadyD;
  logic [31:0]        InstrD;
  logic [D_WIDTH-1:0] PCD;
  logic [D_WIDTH-1:0] PCPlus4D;
  logic               MisalignF;

  modport master (
    output PC, Instr, RedirectE, PCTargetE, ReadyD,
    input  PCNext, ValidD, InstrD, PCD, PCPlus4D, MisalignF
  );

  modport slave (
    input  PC, Instr, RedirectE, PCTargetE, ReadyD,
    output PCNext, ValidD, InstrD, PCD, PCPlus4D, MisalignF
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: reads the instruction word at PC, queues {Instr, PC, PC+4}
// in a DEPTH-entry in-order FIFO and hands the head to decode with a
// valid/ready handshake. A redirect from execute flushes the queue and
// steers PCNext to the target. The queue head is held in registers, so
// there is no combinational path from Instr to InstrD.
//
// Optional feature, macro FETCH_MISALIGN_CHECK_EN: a redirect to a target
// that is not word aligned sets a sticky MisalignF flag (cleared only by
// rst) that freezes the PC and blocks further pushes while the queue drains.
// Without the macro MisalignF is tied low and targets are used unchecked.
module fetch_stage #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 2
) (
  input  logic          CLK,
  input  logic          rst,
  fetch_stage_if.slave  fif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0]   PTR_ZERO = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [D_WIDTH-1:0] PC_STEP  = D_WIDTH'(3'd4);

  // Sequential PC increment; wraps modulo 2^D_WIDTH by truncation.
  function automatic logic [D_WIDTH-1:0] pc_plus4(input logic [D_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Queue storage and bookkeeping
  logic [31:0]        instr_q [DEPTH];
  logic [D_WIDTH-1:0] pc_q    [DEPTH];
  logic [D_WIDTH-1:0] pc4_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic               empty_s;
  logic               full_s;
  logic               valid_s;
  logic               pop_s;
  logic               push_s;
  logic               misalign_s;
  logic [D_WIDTH-1:0] pc_plus4_s;
  logic [D_WIDTH-1:0] pc_next_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Sticky flag: set by any redirect whose target is not word aligned.
  always_comb begin
    misalign_d = misalign_q;
    if (fif.RedirectE && (fif.PCTargetE[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Misalign flag register; only rst clears it.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_s = misalign_q;
`else
  assign misalign_s = 1'b0;
`endif

  // Handshake: the head is offered only when no flush is pending, and a
  // full queue may still accept a word when the head leaves on the same edge.
  always_comb begin
    empty_s    = (count_q == CNT_ZERO);
    full_s     = (count_q == CNT_FULL);
    valid_s    = !empty_s && !fif.RedirectE && !rst;
    pop_s      = valid_s && fif.ReadyD;
    push_s     = (!full_s || pop_s) && !fif.RedirectE && !rst && !misalign_s;
    pc_plus4_s = pc_plus4(fif.PC);
  end

  // Next PC: redirect wins, then sequential advance on push, else hold.
  always_comb begin
    pc_next_s = fif.PC;
    if (rst) begin
      pc_next_s = fif.PC;
    end else if (misalign_s) begin
      pc_next_s = fif.PC;
    end else if (fif.RedirectE) begin
      pc_next_s = fif.PCTargetE;
    end else if (push_s) begin
      pc_next_s = pc_plus4_s;
    end else begin
      pc_next_s = fif.PC;
    end
  end

  // Pointer/count next state; a redirect empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fif.RedirectE) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'd0;
        pc_q[i]    <= D_WIDTH'(1'b0);
        pc4_q[i]   <= D_WIDTH'(1'b0);
      end
    end else if (push_s) begin
      instr_q[wr_ptr_q] <= fif.Instr;
      pc_q[wr_ptr_q]    <= fif.PC;
      pc4_q[wr_ptr_q]   <= pc_plus4_s;
    end else begin
      instr_q[wr_ptr_q] <= instr_q[wr_ptr_q];
    end
  end

  assign fif.PCNext    = pc_next_s;
  assign fif.ValidD    = valid_s;
  assign fif.InstrD    = instr_q[rd_ptr_q];
  assign fif.PCD       = pc_q[rd_ptr_q];
  assign fif.PCPlus4D  = pc4_q[rd_ptr_q];
  assign fif.MisalignF = misalign_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based reference model of the
// fetch rules, directed sequences with literal expectations, then random
// ready/redirect traffic checked every cycle by one compare process.
module tb_fetch_stage;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_stage_if #(.D_WIDTH(DW)) bus();

  fetch_stage #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .rst (rst),
    .fif (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign bus.Instr = imem(bus.PC);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_mis;
  bit          e_valid, e_pop, e_push;
  logic [31:0] e_pcnext;
  ent_t        e_head;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current inputs and model queue.
  function void compute_exp();
    e_valid = (q.size() != 0) && !bus.RedirectE && !rst;
    e_pop   = e_valid && bus.ReadyD;
    e_push  = !rst && !bus.RedirectE && !m_mis && ((q.size() < DEPTH) || e_pop);
    if (rst || m_mis)        e_pcnext = bus.PC;
    else if (bus.RedirectE)  e_pcnext = bus.PCTargetE;
    else if (e_push)         e_pcnext = bus.PC + 32'd4;
    else                     e_pcnext = bus.PC;
    e_head = e_valid ? q[0] : '0;
  endfunction

  // Advance the model across one rising edge.
  function void model_edge();
    if (rst) begin
      q.delete();
      m_mis = 1'b0;
    end else if (bus.RedirectE) begin
      q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bus.PCTargetE[1:0] != 2'b00) m_mis = 1'b1;
`endif
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back({imem(bus.PC), bus.PC});
    end
    m_pc = e_pcnext;
  endfunction

  // One cycle: model edge, new inputs 1ns later, return at posedge+4.
  task automatic drive(input bit rdy, input bit red, input logic [31:0] tgt);
    @(posedge clk);
    model_edge();
    #1;
    bus.ReadyD    = rdy;
    bus.RedirectE = red;
    bus.PCTargetE = tgt;
    bus.PC        = m_pc;
    compute_exp();
    #3;
  endtask

  task automatic release_rst();
    @(posedge clk);
    model_edge();
    #1;
    rst    = 1'b0;
    bus.PC = m_pc;
    compute_exp();
    #3;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ValidD", 32'(bus.ValidD), 32'(e_valid));
      chk("PCNext", bus.PCNext, e_pcnext);
      chk("MisalignF", 32'(bus.MisalignF), 32'(m_mis));
      if (e_valid || rst) begin
        chk("InstrD", bus.InstrD, e_head.instr);
        chk("PCD", bus.PCD, e_head.pc);
        chk("PCPlus4D", bus.PCPlus4D, rst ? 32'd0 : e_head.pc + 32'd4);
      end
    end
  end

  initial begin
    logic [31:0] t;
    bit          r, red;

    bus.PC = 32'd0; bus.ReadyD = 1'b1; bus.RedirectE = 1'b0; bus.PCTargetE = 32'd0;
    m_pc = 32'd0; m_mis = 1'b0;
    #1 rst = 1'b1;
    compute_exp();
    #1;
    chk("rst_ValidD", 32'(bus.ValidD), 32'd0);
    chk("rst_InstrD", bus.InstrD, 32'd0);
    chk("rst_PCD", bus.PCD, 32'd0);
    chk("rst_PCPlus4D", bus.PCPlus4D, 32'd0);
    chk("rst_PCNext", bus.PCNext, 32'd0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    release_rst();

    // Startup from PC 0 with decode always ready
    chk("c0_PCNext", bus.PCNext, 32'h4);
    chk("c0_ValidD", 32'(bus.ValidD), 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk("c1_ValidD", 32'(bus.ValidD), 32'd1);
    chk("c1_PCD", bus.PCD, 32'h0);
    chk("c1_PCPlus4D", bus.PCPlus4D, 32'h4);
    chk("c1_InstrD", bus.InstrD, imem(32'h0));

    // Decode stalls for four cycles: queue fills, PC holds
    drive(1'b0, 1'b0, 32'd0);
    chk("c2_PCNext", bus.PCNext, 32'hC);
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    chk("stall_PCNext", bus.PCNext, 32'hC);
    chk("stall_PCD", bus.PCD, 32'h4);
    chk("stall_ValidD", 32'(bus.ValidD), 32'd1);

    // Full queue drains in order while refilling
    drive(1'b1, 1'b0, 32'd0);
    chk("full_PCD0", bus.PCD, 32'h4);
    chk("full_PCNext", bus.PCNext, 32'h10);
    drive(1'b1, 1'b0, 32'd0);
    chk("full_PCD1", bus.PCD, 32'h8);

    // Redirect with two entries queued
    drive(1'b1, 1'b1, 32'h100);
    chk("redir_ValidD", 32'(bus.ValidD), 32'd0);
    chk("redir_PCNext", bus.PCNext, 32'h100);
    drive(1'b1, 1'b0, 32'd0);
    chk("redir_empty", 32'(bus.ValidD), 32'd0);
    chk("redir_PCNext2", bus.PCNext, 32'h104);
    drive(1'b1, 1'b0, 32'd0);
    chk("redir_PCD", bus.PCD, 32'h100);

    // PC+4 wraps at the top of the address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'd0);
    chk("wrap_PCNext", bus.PCNext, 32'h0);
    drive(1'b1, 1'b0, 32'd0);
    chk("wrap_PCD", bus.PCD, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4D", bus.PCPlus4D, 32'h0);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    q.delete();
    m_mis = 1'b0;
    compute_exp();
    #1;
    chk("arst_ValidD", 32'(bus.ValidD), 32'd0);
    chk("arst_InstrD", bus.InstrD, 32'd0);
    chk("arst_PCD", bus.PCD, 32'd0);
    chk("arst_PCPlus4D", bus.PCPlus4D, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    release_rst();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 3) != 0);
      red = ($urandom_range(0, 11) == 0);
      t   = $urandom();
      t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
      drive(r, red, t);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect freezes fetch until reset
    drive(1'b1, 1'b1, 32'h102);
    drive(1'b1, 1'b0, 32'd0);
    chk("mis_flag", 32'(bus.MisalignF), 32'd1);
    chk("mis_PCNext", bus.PCNext, 32'h102);
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    chk("mis_hold", bus.PCNext, 32'h102);
    chk("mis_nopush", 32'(bus.ValidD), 32'd0);
    #2 rst = 1'b1;
    q.delete();
    m_mis = 1'b0;
    compute_exp();
    #1;
    chk("mis_rst", 32'(bus.MisalignF), 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    release_rst();
    drive(1'b1, 1'b0, 32'd0);
`endif

    drive(1'b1, 1'b0, 32'd0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter D_WIDTH, default 32, address/PC width.
REQ-002 SHALL provide parameter DEPTH, default 2, fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PC  input  D_WIDTH  current PC from the PC register.
REQ-006 SHALL have port PCNext  output  D_WIDTH  next PC, driven to the PC register.
REQ-007 SHALL have port Instr  input  32  instruction memory word read combinationally at PC.
REQ-008 SHALL have port RedirectE  input  1  taken branch/jump from execute.
REQ-009 SHALL have port PCTargetE  input  D_WIDTH  redirect target.
REQ-010 SHALL have port ValidD  output  1  queue head valid toward decode.
REQ-011 SHALL have port ReadyD  input  1  decode accepts head.
REQ-012 SHALL have port InstrD  output  32  head instruction.
REQ-013 SHALL have port PCD  output  D_WIDTH  head PC.
REQ-014 SHALL have port PCPlus4D  output  D_WIDTH  head PC+4.
REQ-015 SHALL have port MisalignF  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL hold a DEPTH-entry in-order FIFO of {Instr, PC, PC+4}; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-017 pop SHALL = ValidD && ReadyD; ValidD SHALL = !empty && !RedirectE && !rst.
REQ-018 push SHALL = (!full || pop) && !RedirectE && !rst; full with simultaneous pop SHALL push and pop in the same edge, count unchanged.
REQ-019 PCNext SHALL = PCTargetE if RedirectE; else PC+4 if push; else PC (stall).
REQ-020 PC+4 arithmetic SHALL wrap modulo 2^D_WIDTH.
REQ-021 Latency: word pushed at edge n SHALL be visible at the head (ValidD=1 if no redirect) in cycle n+1; no combinational path Instr -> InstrD.
REQ-022 RedirectE SHALL clear the FIFO (count=0, pointers=0) at the next edge; any simultaneous pop is suppressed; the first word from PCTargetE is pushed the following cycle.
REQ-023 Empty queue with ReadyD=1: no pop, no state change beyond push.
REQ-024 InstrD/PCD/PCPlus4D SHALL reflect the head entry; values while ValidD=0 are don't-care except after reset.

Reset
REQ-025 rst assertion SHALL asynchronously clear count, pointers, MisalignF, and drive InstrD=0, PCD=0, PCPlus4D=0, ValidD=0, including mid-operation.
REQ-026 While rst is high, PCNext SHALL = PC and no push shall occur; normal fetch resumes at the first edge after deassertion.

Configuration
REQ-027 With macro FETCH_MISALIGN_CHECK_EN defined: RedirectE with PCTargetE[1:0]!=0 SHALL set MisalignF at the next edge, sticky until rst; while MisalignF=1, push SHALL be 0, PCNext SHALL = PC, and queued entries SHALL still drain.
REQ-028 Without FETCH_MISALIGN_CHECK_EN: MisalignF SHALL be tied 0 and PCTargetE is used unchecked.

Verification
REQ-029 Reset then PC=0x0, ReadyD=1 held: PCNext=0x4 each push cycle; first ValidD=1 one cycle later with PCD=0x0, PCPlus4D=0x4.
REQ-030 ReadyD=0 for 4 cycles, DEPTH=2: two entries queued, then PCNext=PC (stall), ValidD=1 holds PCD of oldest entry.
REQ-031 Queue full, ReadyD=1: push and pop same edge, count stays 2, order preserved (PCD sequence 0x0,0x4,0x8).
REQ-032 RedirectE=1, PCTargetE=0x100 with 2 entries queued: ValidD=0 that cycle, PCNext=0x100, queue empty next cycle, next head PCD=0x100.
REQ-033 rst asserted between clock edges mid-stream: ValidD, InstrD, PCD, PCPlus4D go 0 immediately, without waiting for CLK.
REQ-034 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102: MisalignF=1 next cycle, PCNext=PC thereafter, no new pushes until rst.
